// File: rtl/dfio_pkg.sv
// Shared dfio word definitions, common to the dfio source and receive buffer.
package dfio_pkg;
  localparam int DFIO_W = 32;
  typedef logic [DFIO_W-1:0] dfio_word_t;
endpackage

// File: rtl/dfio_rx_mem.sv
// Storage array for the dfio receive FIFO: one synchronous write port, one async read port.
// Storage is deliberately unreset; validity is tracked by the pointers in the top.
import dfio_pkg::*;

module dfio_rx_mem #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  dfio_word_t    wdata,
  input  logic [AW-1:0] raddr,
  output dfio_word_t    rdata
);

  dfio_word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dfio_rx_buffer.sv
// Receive-side FWFT FIFO for dfio words with valid/ready output and sticky overflow flag.
// Optional DFIO_RX_OVF_CNT_EN adds a saturating 16-bit dropped-word counter on ovf_cnt.
import dfio_pkg::*;

module dfio_rx_buffer #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  dfio_word_t  din,
  output dfio_word_t  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty,
  output logic        overflow,
`ifdef DFIO_RX_OVF_CNT_EN
  output logic [15:0] ovf_cnt,
`endif
  input  logic        clr_ovf
);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        push;
  logic        pop;
  logic        drop;

  // Extra pointer MSB separates full from empty when the low bits match.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level      = wr_ptr - rd_ptr;
  assign dout_valid = ~empty;

  assign pop  = dout_valid & dout_ready;
  assign push = enable & (~full | pop);
  assign drop = enable & full & ~pop;

  dfio_rx_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (din),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (dout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // A drop in the same cycle as clr_ovf keeps the flag set.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

`ifdef DFIO_RX_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (clr_ovf) begin
      ovf_cnt <= drop ? 16'd1 : 16'd0;
    end else if (drop && ovf_cnt != 16'hFFFF) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dfio_rx_buffer.sv
// Self-checking bench for dfio_rx_buffer: queue-based reference model, directed pins, random traffic.
module tb_dfio_rx_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [3:0]  level;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        clr_ovf = 1'b0;
`ifdef DFIO_RX_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  dfio_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
`ifdef DFIO_RX_OVF_CNT_EN
    .ovf_cnt    (ovf_cnt),
`endif
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  logic [31:0] q[$];
  bit          m_ovf = 1'b0;
  int          m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, settle.
  task automatic cyc(input bit en, input logic [31:0] d, input bit rdy, input bit clr, input bit rs);
    bit was_full, do_pop, do_drop;
    enable = en; din = d; dout_ready = rdy; clr_ovf = clr; rst = rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_ovf = 1'b0;
      m_cnt = 0;
    end else begin
      was_full = (q.size() == DEPTH);
      do_pop   = (q.size() > 0) && rdy;
      do_drop  = en && was_full && !do_pop;
      if (do_pop) void'(q.pop_front());
      if (en && !do_drop) q.push_back(d);
      if (do_drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (clr) m_cnt = do_drop ? 1 : 0;
      else if (do_drop && m_cnt < 65535) m_cnt++;
    end
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fill_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, base + i, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain_expect(input string name, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      chk({name, "_valid"}, {31'b0, dout_valid}, 32'd1);
      chk({name, "_data"}, dout, base + i);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    chk({name, "_empty"}, {31'b0, empty}, 32'd1);
  endtask

  // Compare process: every cycle the DUT is checked against the queue model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", {31'b0, dout_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) chk("m_dout", dout, q[0]);
      chk("m_level", {28'b0, level}, q.size());
      chk("m_full", {31'b0, full}, {31'b0, q.size() == DEPTH});
      chk("m_empty", {31'b0, empty}, {31'b0, q.size() == 0});
      chk("m_ovf", {31'b0, overflow}, {31'b0, m_ovf});
`ifdef DFIO_RX_OVF_CNT_EN
      chk("m_cnt", {16'b0, ovf_cnt}, m_cnt);
`endif
    end
  end

  initial begin
    // 1: reset held two cycles
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_level", {28'b0, level}, 32'd0);
    chk("rst_valid", {31'b0, dout_valid}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // 2: single word, one-cycle latency
    cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    chk("single_valid", {31'b0, dout_valid}, 32'd1);
    chk("single_dout", dout, 32'hDEADBEEF);
    chk("single_level", {28'b0, level}, 32'd1);
    idle();
    chk("single_hold", dout, 32'hDEADBEEF);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("single_empty", {31'b0, empty}, 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("ready_empty_lvl", {28'b0, level}, 32'd0);

    // 3: fill/drain order, three passes to wrap pointers
    for (int r = 0; r < 3; r++) begin
      fill_seq(32'd1, 8);
      chk("fill_full", {31'b0, full}, 32'd1);
      chk("fill_level", {28'b0, level}, 32'd8);
      drain_expect("fill_drain", 32'd1, 8);
    end

    // 4: overflow drop and clear
    fill_seq(32'd1, 8);
    cyc(1'b1, 32'h00000BAD, 1'b0, 1'b0, 1'b0);
    chk("ovf_flag", {31'b0, overflow}, 32'd1);
    chk("ovf_level", {28'b0, level}, 32'd8);
`ifdef DFIO_RX_OVF_CNT_EN
    chk("ovf_cnt1", {16'b0, ovf_cnt}, 32'd1);
`endif
    drain_expect("ovf_drain", 32'd1, 8);
    chk("ovf_sticky", {31'b0, overflow}, 32'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("ovf_clr", {31'b0, overflow}, 32'd0);
`ifdef DFIO_RX_OVF_CNT_EN
    chk("ovf_cnt_clr", {16'b0, ovf_cnt}, 32'd0);
`endif

    // drop in the same cycle as clr_ovf: set wins
    fill_seq(32'h40, 8);
    cyc(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("clr_drop_ovf", {31'b0, overflow}, 32'd1);
`ifdef DFIO_RX_OVF_CNT_EN
    chk("clr_drop_cnt", {16'b0, ovf_cnt}, 32'd1);
`endif
    drain_expect("clr_drop_drain", 32'h40, 8);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // 5: push and pop together while full
    fill_seq(32'd1, 8);
    cyc(1'b1, 32'd9, 1'b1, 1'b0, 1'b0);
    chk("fpp_ovf", {31'b0, overflow}, 32'd0);
    chk("fpp_level", {28'b0, level}, 32'd8);
    drain_expect("fpp_drain", 32'd2, 8);

    // 6: reset mid-operation discards stored words
    fill_seq(32'h100, 5);
    chk("mid_level", {28'b0, level}, 32'd5);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("mid_empty", {31'b0, empty}, 32'd1);
    cyc(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    chk("mid_new_dout", dout, 32'h77);
    chk("mid_new_level", {28'b0, level}, 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // random traffic against the model, with varying load
    for (int i = 0; i < 4000; i++) begin
      int phase;
      phase = i / 500;
      cyc($urandom_range(99, 0) < ((phase % 2 == 0) ? 70 : 35),
          $urandom(),
          $urandom_range(99, 0) < ((phase % 2 == 0) ? 35 : 70),
          $urandom_range(99, 0) < 3,
          $urandom_range(999, 0) < 3);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
